// File: rtl/cat_trap_controller.sv
// -----------------------------------------------------------------------------
// cat_trap_controller
//
// Game sequencer for the 8x8 cat-trap board. Holds the board registers, the
// player cursor, wall placement, the one-cycle cat-move scheduler and the
// win/lose result hold. The renderer reads cells through a combinational port
// and takes its background colour from this block.
//
// Ports
//   i_clk                 system clock
//   i_reset               asynchronous, active-high reset
//   i_btn_up/down/left/right  cursor movement pulses (debounced, 1 cycle)
//   i_btn_center          start game (IDLE) / place wall (PLAY) pulse
//   i_rd_row, i_rd_col    renderer read address
//   o_rd_cell             cell at read address: 0 empty, 1 wall, 2 cat
//   o_cursor_row/col      current cursor position
//   o_cat_row/col         current cat position
//   o_moves               walls placed this game, saturates at 255
//   o_game_state          0 IDLE, 1 PLAY, 2 CAT_MOVE, 3 WIN, 4 LOSE
//   o_background          renderer background colour (12-bit RGB)
// -----------------------------------------------------------------------------
module cat_trap_controller #(
  parameter int CAT_START_ROW = 4,
  parameter int CAT_START_COL = 4,
  parameter int RESULT_CYCLES = 50_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_btn_up,
  input  logic        i_btn_down,
  input  logic        i_btn_left,
  input  logic        i_btn_right,
  input  logic        i_btn_center,
  input  logic [2:0]  i_rd_row,
  input  logic [2:0]  i_rd_col,
  output logic [1:0]  o_rd_cell,
  output logic [2:0]  o_cursor_row,
  output logic [2:0]  o_cursor_col,
  output logic [2:0]  o_cat_row,
  output logic [2:0]  o_cat_col,
  output logic [7:0]  o_moves,
  output logic [2:0]  o_game_state,
  output logic [11:0] o_background
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY     = 3'd1,
    S_CAT_MOVE = 3'd2,
    S_WIN      = 3'd3,
    S_LOSE     = 3'd4
  } state_t;

  localparam logic [1:0]  CELL_EMPTY = 2'd0;
  localparam logic [1:0]  CELL_WALL  = 2'd1;
  localparam logic [1:0]  CELL_CAT   = 2'd2;

  localparam logic [11:0] BG_IDLE = 12'hFFF;
  localparam logic [11:0] BG_WIN  = 12'h0F0;
  localparam logic [11:0] BG_LOSE = 12'hF00;

  localparam logic [2:0]   START_ROW  = 3'(CAT_START_ROW);
  localparam logic [2:0]   START_COL  = 3'(CAT_START_COL);
  localparam logic [5:0]   START_IDX  = {START_ROW, START_COL};
  // Board is packed as 64 two-bit cells; cell index {row,col} lives at bits
  // [2*idx +: 2].
  localparam logic [127:0] BOARD_INIT = 128'd2 << {START_IDX, 1'b0};

  // Hold counter counts 0 .. RESULT_CYCLES-1, so the result screen lasts
  // exactly RESULT_CYCLES cycles.
  localparam int                HOLD_W    = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESULT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

  function automatic logic [5:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

  function automatic logic [1:0] cell_at(input logic [127:0] board, input logic [5:0] idx);
    return board[{idx, 1'b0} +: 2];
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  state_t            r_state,      w_state_next;
  logic [127:0]      r_board,      w_board_next;
  logic [2:0]        r_cur_row,    w_cur_row_next;
  logic [2:0]        r_cur_col,    w_cur_col_next;
  logic [2:0]        r_cat_row,    w_cat_row_next;
  logic [2:0]        r_cat_col,    w_cat_col_next;
  logic [7:0]        r_moves,      w_moves_next;
  logic [HOLD_W-1:0] r_hold,       w_hold_next;
  logic [11:0]       r_background, w_background_next;

  // ---------------------------------------------------------------------------
  // Cat-move candidate evaluation
  // ---------------------------------------------------------------------------
  logic       w_down_off, w_up_off, w_right_off, w_left_off;
  logic       w_down_wall, w_up_wall, w_right_wall, w_left_wall;
  logic [5:0] w_down_idx, w_up_idx, w_right_idx, w_left_idx;
  logic       w_pick_valid;
  logic       w_pick_off;
  logic [2:0] w_pick_row, w_pick_col;

  logic [5:0] w_cur_idx;
  logic [1:0] w_cur_cell;
  logic [7:0] w_moves_inc;

  assign w_cur_idx   = cell_idx(r_cur_row, r_cur_col);
  assign w_cur_cell  = cell_at(r_board, w_cur_idx);
  assign w_moves_inc = (r_moves == 8'd255) ? r_moves : (r_moves + 8'd1);

  // Edge flags are evaluated first; a wrapped neighbour index is only ever
  // looked at when the matching off-board flag is clear.
  assign w_down_off  = (r_cat_row == 3'd7);
  assign w_up_off    = (r_cat_row == 3'd0);
  assign w_right_off = (r_cat_col == 3'd7);
  assign w_left_off  = (r_cat_col == 3'd0);

  assign w_down_idx  = cell_idx(r_cat_row + 3'd1, r_cat_col);
  assign w_up_idx    = cell_idx(r_cat_row - 3'd1, r_cat_col);
  assign w_right_idx = cell_idx(r_cat_row, r_cat_col + 3'd1);
  assign w_left_idx  = cell_idx(r_cat_row, r_cat_col - 3'd1);

  assign w_down_wall  = !w_down_off  && (cell_at(r_board, w_down_idx)  == CELL_WALL);
  assign w_up_wall    = !w_up_off    && (cell_at(r_board, w_up_idx)    == CELL_WALL);
  assign w_right_wall = !w_right_off && (cell_at(r_board, w_right_idx) == CELL_WALL);
  assign w_left_wall  = !w_left_off  && (cell_at(r_board, w_left_idx)  == CELL_WALL);

  // Pick the first non-wall candidate in the order down, up, right, left.
  // An off-board candidate is not a wall, so it can be picked (and loses).
  always_comb begin
    w_pick_valid = 1'b1;
    w_pick_off   = 1'b0;
    w_pick_row   = r_cat_row;
    w_pick_col   = r_cat_col;
    if (!w_down_wall) begin
      w_pick_off = w_down_off;
      w_pick_row = r_cat_row + 3'd1;
    end else if (!w_up_wall) begin
      w_pick_off = w_up_off;
      w_pick_row = r_cat_row - 3'd1;
    end else if (!w_right_wall) begin
      w_pick_off = w_right_off;
      w_pick_col = r_cat_col + 3'd1;
    end else if (!w_left_wall) begin
      w_pick_off = w_left_off;
      w_pick_col = r_cat_col - 3'd1;
    end else begin
      w_pick_valid = 1'b0;
    end
  end

  // Next-state and datapath update for the game sequencer.
  always_comb begin
    w_state_next      = r_state;
    w_board_next      = r_board;
    w_cur_row_next    = r_cur_row;
    w_cur_col_next    = r_cur_col;
    w_cat_row_next    = r_cat_row;
    w_cat_col_next    = r_cat_col;
    w_moves_next      = r_moves;
    w_hold_next       = r_hold;
    w_background_next = r_background;

    case (r_state)
      S_IDLE: begin
        if (i_btn_center) begin
          w_state_next = S_PLAY;
        end else begin
          w_state_next = S_IDLE;
        end
      end

      S_PLAY: begin
        // Center takes priority over every direction, even when the
        // placement itself is refused.
        if (i_btn_center) begin
          if (w_cur_cell == CELL_EMPTY) begin
            w_board_next[{w_cur_idx, 1'b0} +: 2] = CELL_WALL;
            w_moves_next = w_moves_inc;
            w_state_next = S_CAT_MOVE;
          end else begin
            w_state_next = S_PLAY;
          end
        end else if (i_btn_up) begin
          w_cur_row_next = (r_cur_row == 3'd0) ? r_cur_row : (r_cur_row - 3'd1);
        end else if (i_btn_down) begin
          w_cur_row_next = (r_cur_row == 3'd7) ? r_cur_row : (r_cur_row + 3'd1);
        end else if (i_btn_left) begin
          w_cur_col_next = (r_cur_col == 3'd0) ? r_cur_col : (r_cur_col - 3'd1);
        end else if (i_btn_right) begin
          w_cur_col_next = (r_cur_col == 3'd7) ? r_cur_col : (r_cur_col + 3'd1);
        end else begin
          w_state_next = S_PLAY;
        end
      end

      S_CAT_MOVE: begin
        w_hold_next = HOLD_ZERO;
        if (!w_pick_valid) begin
          w_state_next      = S_WIN;
          w_background_next = BG_WIN;
        end else if (w_pick_off) begin
          w_state_next      = S_LOSE;
          w_background_next = BG_LOSE;
        end else begin
          w_board_next[{cell_idx(r_cat_row, r_cat_col), 1'b0} +: 2]   = CELL_EMPTY;
          w_board_next[{cell_idx(w_pick_row, w_pick_col), 1'b0} +: 2] = CELL_CAT;
          w_cat_row_next = w_pick_row;
          w_cat_col_next = w_pick_col;
          w_state_next   = S_PLAY;
        end
      end

      S_WIN, S_LOSE: begin
        if (r_hold == HOLD_LAST) begin
          w_state_next      = S_IDLE;
          w_board_next      = BOARD_INIT;
          w_cur_row_next    = 3'd0;
          w_cur_col_next    = 3'd0;
          w_cat_row_next    = START_ROW;
          w_cat_col_next    = START_COL;
          w_moves_next      = 8'd0;
          w_hold_next       = HOLD_ZERO;
          w_background_next = BG_IDLE;
        end else begin
          w_hold_next = r_hold + HOLD_W'(1);
        end
      end

      default: begin
        // Unreachable encodings recover to a freshly initialised board.
        w_state_next      = S_IDLE;
        w_board_next      = BOARD_INIT;
        w_cur_row_next    = 3'd0;
        w_cur_col_next    = 3'd0;
        w_cat_row_next    = START_ROW;
        w_cat_col_next    = START_COL;
        w_moves_next      = 8'd0;
        w_hold_next       = HOLD_ZERO;
        w_background_next = BG_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous board initialisation.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_board      <= BOARD_INIT;
      r_cur_row    <= 3'd0;
      r_cur_col    <= 3'd0;
      r_cat_row    <= START_ROW;
      r_cat_col    <= START_COL;
      r_moves      <= 8'd0;
      r_hold       <= HOLD_ZERO;
      r_background <= BG_IDLE;
    end else begin
      r_state      <= w_state_next;
      r_board      <= w_board_next;
      r_cur_row    <= w_cur_row_next;
      r_cur_col    <= w_cur_col_next;
      r_cat_row    <= w_cat_row_next;
      r_cat_col    <= w_cat_col_next;
      r_moves      <= w_moves_next;
      r_hold       <= w_hold_next;
      r_background <= w_background_next;
    end
  end

  // Renderer read port: a plain mux of the board registers.
  assign o_rd_cell    = cell_at(r_board, cell_idx(i_rd_row, i_rd_col));

  assign o_cursor_row = r_cur_row;
  assign o_cursor_col = r_cur_col;
  assign o_cat_row    = r_cat_row;
  assign o_cat_col    = r_cat_col;
  assign o_moves      = r_moves;
  assign o_game_state = r_state;
  assign o_background = r_background;

endmodule

// File: tb/tb_cat_trap_controller.sv
// -----------------------------------------------------------------------------
// tb_cat_trap_controller
//
// Directed bench for cat_trap_controller with RESULT_CYCLES=4 and the cat
// starting at (4,4). Expected values are hand-derived from the game rules.
// -----------------------------------------------------------------------------
module tb_cat_trap_controller;

  localparam logic [4:0] B_UP    = 5'b10000;
  localparam logic [4:0] B_DOWN  = 5'b01000;
  localparam logic [4:0] B_LEFT  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b00010;
  localparam logic [4:0] B_CTR   = 5'b00001;

  logic        clk;
  logic        reset;
  logic        btn_up, btn_down, btn_left, btn_right, btn_center;
  logic [2:0]  rd_row, rd_col;
  logic [1:0]  rd_cell;
  logic [2:0]  cursor_row, cursor_col, cat_row, cat_col, game_state;
  logic [7:0]  moves;
  logic [11:0] background;

  int n_vec;
  int n_err;
  int cur_r;
  int cur_c;

  cat_trap_controller #(
    .CAT_START_ROW(4),
    .CAT_START_COL(4),
    .RESULT_CYCLES(4)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_btn_up     (btn_up),
    .i_btn_down   (btn_down),
    .i_btn_left   (btn_left),
    .i_btn_right  (btn_right),
    .i_btn_center (btn_center),
    .i_rd_row     (rd_row),
    .i_rd_col     (rd_col),
    .o_rd_cell    (rd_cell),
    .o_cursor_row (cursor_row),
    .o_cursor_col (cursor_col),
    .o_cat_row    (cat_row),
    .o_cat_col    (cat_col),
    .o_moves      (moves),
    .o_game_state (game_state),
    .o_background (background)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int exp);
    chk({tag, ".state"}, 32'(game_state), 32'(exp));
  endtask

  task automatic chk_cat(input string tag, input int r, input int c);
    chk({tag, ".cat_row"}, 32'(cat_row), 32'(r));
    chk({tag, ".cat_col"}, 32'(cat_col), 32'(c));
  endtask

  task automatic chk_cursor(input string tag, input int r, input int c);
    chk({tag, ".cursor_row"}, 32'(cursor_row), 32'(r));
    chk({tag, ".cursor_col"}, 32'(cursor_col), 32'(c));
  endtask

  task automatic chk_cell(input string tag, input int r, input int c, input int exp);
    rd_row = 3'(r);
    rd_col = 3'(c);
    #1;
    chk($sformatf("%s.cell(%0d,%0d)", tag, r, c), 32'(rd_cell), 32'(exp));
  endtask

  // One-cycle button pulse; returns 1 ns after the sampling edge.
  task automatic press(input logic [4:0] b);
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right, btn_center} = b;
    @(posedge clk);
    #1;
    {btn_up, btn_down, btn_left, btn_right, btn_center} = 5'b00000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int r, input int c);
    while (cur_r < r) begin press(B_DOWN);  cur_r++; end
    while (cur_r > r) begin press(B_UP);    cur_r--; end
    while (cur_c < c) begin press(B_RIGHT); cur_c++; end
    while (cur_c > c) begin press(B_LEFT);  cur_c--; end
    chk_cursor("goto", cur_r, cur_c);
  endtask

  // Place a wall at the cursor, then check the cat's response.
  task automatic place(input int cat_r, input int cat_c, input int exp_state);
    press(B_CTR);
    chk_cell("place", cur_r, cur_c, 1);
    chk_state("place", 2);
    tick();
    chk_state("catmove", exp_state);
    chk_cat("catmove", cat_r, cat_c);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cur_r = 0;
    cur_c = 0;
    reset = 1'b1;
    {btn_up, btn_down, btn_left, btn_right, btn_center} = 5'b00000;
    rd_row = 3'd0;
    rd_col = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset state
    chk_state("rst", 0);
    chk_cursor("rst", 0, 0);
    chk_cat("rst", 4, 4);
    chk("rst.moves", 32'(moves), 32'd0);
    chk("rst.bg", 32'(background), 32'hFFF);
    chk_cell("rst", 4, 4, 2);

    // IDLE ignores directions; center starts the game
    press(B_DOWN);
    chk_cursor("idle_down", 0, 0);
    repeat (9) press(B_UP);
    press(B_CTR);
    chk_state("start", 1);
    chk_cursor("start", 0, 0);

    // Cursor saturation at 7 and back at 0
    repeat (9) press(B_DOWN);
    chk("sat7.cursor_row", 32'(cursor_row), 32'd7);
    repeat (9) press(B_UP);
    chk("sat0.cursor_row", 32'(cursor_row), 32'd0);

    // First placement at (0,0): wall after one edge, cat after the next
    press(B_CTR);
    chk_cell("p1", 0, 0, 1);
    chk_state("p1", 2);
    chk("p1.moves", 32'(moves), 32'd1);
    tick();
    chk_state("p1m", 1);
    chk_cat("p1m", 5, 4);
    chk_cell("p1m", 4, 4, 0);
    chk_cell("p1m", 5, 4, 2);
    chk("p1m.moves", 32'(moves), 32'd1);

    // Center on an occupied cell is ignored
    press(B_CTR);
    chk_state("dup", 1);
    chk("dup.moves", 32'(moves), 32'd1);
    chk_cat("dup", 5, 4);

    // Walk the cat off the bottom edge
    goto(0, 1);
    place(6, 4, 1);
    goto(0, 2);
    place(7, 4, 1);
    goto(0, 3);
    place(7, 4, 4);
    chk("lose.bg", 32'(background), 32'hF00);
    chk("lose.moves", 32'(moves), 32'd4);

    // Result hold of 4 cycles; center during LOSE is dropped
    press(B_CTR);
    chk_state("hold1", 4);
    tick();
    tick();
    chk_state("hold3", 4);
    tick();
    chk_state("lose_exit", 0);
    chk("lose_exit.bg", 32'(background), 32'hFFF);
    chk_cat("lose_exit", 4, 4);
    chk("lose_exit.moves", 32'(moves), 32'd0);
    chk_cursor("lose_exit", 0, 0);
    chk_cell("lose_exit", 0, 0, 0);
    chk_cell("lose_exit", 0, 3, 0);
    chk_cell("lose_exit", 7, 4, 0);
    chk_cell("lose_exit", 4, 4, 2);
    tick();
    chk_state("no_queue", 0);
    cur_r = 0;
    cur_c = 0;

    // Simultaneous buttons
    press(B_CTR);
    chk_state("start2", 1);
    goto(2, 2);
    press(B_UP | B_RIGHT);
    cur_r = 1;
    chk_cursor("up_right", 1, 2);
    press(B_LEFT | B_CTR);
    chk_cursor("left_ctr", 1, 2);
    chk_cell("left_ctr", 1, 2, 1);
    chk_state("left_ctr", 2);
    tick();
    chk_cat("left_ctr_m", 5, 4);
    chk("left_ctr_m.moves", 32'(moves), 32'd1);

    // Asynchronous reset in the middle of CAT_MOVE
    goto(1, 3);
    press(B_CTR);
    chk_state("pre_rst", 2);
    #1;
    reset = 1'b1;
    #1;
    chk_state("mid_rst", 0);
    chk_cat("mid_rst", 4, 4);
    chk("mid_rst.moves", 32'(moves), 32'd0);
    chk("mid_rst.bg", 32'(background), 32'hFFF);
    chk_cursor("mid_rst", 0, 0);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        chk_cell("mid_rst", r, c, (r == 4 && c == 4) ? 2 : 0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    cur_r = 0;
    cur_c = 0;

    // Enclose the cat: it oscillates between (3,4) and (4,4)
    press(B_CTR);
    chk_state("start3", 1);
    goto(5, 4); place(3, 4, 1);
    goto(2, 4); place(4, 4, 1);
    goto(3, 3); place(3, 4, 1);
    goto(3, 5); place(4, 4, 1);
    goto(4, 3); place(3, 4, 1);
    goto(4, 5); place(4, 4, 1);
    goto(3, 4); place(4, 4, 3);
    chk("win.bg", 32'(background), 32'h0F0);
    chk("win.moves", 32'(moves), 32'd7);
    chk_cell("win", 4, 4, 2);
    tick();
    tick();
    tick();
    chk_state("win_hold", 3);
    tick();
    chk_state("win_exit", 0);
    chk("win_exit.bg", 32'(background), 32'hFFF);
    chk_cell("win_exit", 3, 4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
